kbd_action_scheduler: RTL and testbench

Sits between the PS/2 scan-code receiver and the game logic. It consumes set-2 scan-code bytes, decodes the E0 (extended) and F0 (break) prefixes, and maps the keys to two players' actions. For each player it keeps a held-action level vector and buffers press/release events in a small FIFO with a valid/ready handshake.

---
 rtl/kbd_pkg.sv | 78 +++++++
 rtl/kbd_event_fifo.sv | 58 +++++
 rtl/kbd_action_scheduler.sv | 152 +++++++++++++++
 tb/tb_kbd_action_scheduler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared scan-code constants, action codes, FSM encoding and key-map helper.
// Latency: none (types and a combinational function only).
// Backpressure: not applicable.
package kbd_pkg;

    // Set-2 prefix bytes
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;

    // Player 0 keys (non-extended)
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;

    // Player 1 keys: Enter is non-extended, arrows follow an E0 prefix
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Action codes; they also index the held-level vectors
    localparam logic [2:0] ACT_UP    = 3'd0;
    localparam logic [2:0] ACT_DOWN  = 3'd1;
    localparam logic [2:0] ACT_LEFT  = 3'd2;
    localparam logic [2:0] ACT_RIGHT = 3'd3;
    localparam logic [2:0] ACT_BOMB  = 3'd4;

    localparam int EVT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kbd_state_t;

    // FIFO entry: press=1 for make, 0 for break
    typedef struct packed {
        logic       press;
        logic [2:0] action;
    } kbd_evt_t;

    // Result of looking a completed scan code up in the key map
    typedef struct packed {
        logic       hit;
        logic       player;
        logic [2:0] action;
    } key_map_t;

    function automatic key_map_t map_key(input logic [7:0] code, input logic ext);
        key_map_t m;
        m = '0;
        if (!ext) begin
            case (code)
                SC_W:     m = '{hit: 1'b1, player: 1'b0, action: ACT_UP};
                SC_S:     m = '{hit: 1'b1, player: 1'b0, action: ACT_DOWN};
                SC_A:     m = '{hit: 1'b1, player: 1'b0, action: ACT_LEFT};
                SC_D:     m = '{hit: 1'b1, player: 1'b0, action: ACT_RIGHT};
                SC_SPACE: m = '{hit: 1'b1, player: 1'b0, action: ACT_BOMB};
                SC_ENTER: m = '{hit: 1'b1, player: 1'b1, action: ACT_BOMB};
                default:  m = '0;
            endcase
        end else begin
            case (code)
                SC_UP:    m = '{hit: 1'b1, player: 1'b1, action: ACT_UP};
                SC_DOWN:  m = '{hit: 1'b1, player: 1'b1, action: ACT_DOWN};
                SC_LEFT:  m = '{hit: 1'b1, player: 1'b1, action: ACT_LEFT};
                SC_RIGHT: m = '{hit: 1'b1, player: 1'b1, action: ACT_RIGHT};
                default:  m = '0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// First-word-fall-through event FIFO, one instance per player.
// Latency: a push is visible at the head on the next cycle; data_out is 0 when empty.
// Backpressure: a push while full is accepted only if a pop happens the same cycle, otherwise it is ignored.
module kbd_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data_out,
    output logic             full
);
    import kbd_pkg::*;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             pop_do;
    logic             push_do;

    assign valid    = (count != '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign pop_do   = pop & valid;
    // Full FIFO still takes a push when the head leaves in the same cycle
    assign push_do  = push & (~full | pop_do);
    assign data_out = valid ? mem[rd_ptr] : '0;

    // Pointer and occupancy tracking; pointers wrap naturally for power-of-2 depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_do) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_do)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_do, pop_do})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because data_out is masked when empty
    always_ff @(posedge clk) begin
        if (push_do) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/kbd_action_scheduler.sv
// Decodes PS/2 set-2 scan codes into two players' held-action levels and press/release event queues.
// Latency: 1 cycle from code_valid to held-level update and FIFO write.
// Backpressure: per-player valid/ready pop; events arriving at a full, non-popping FIFO are dropped with an overflow pulse.
module kbd_action_scheduler
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code_byte,
    input  logic       code_valid,
    output logic [4:0] held_p0,
    output logic [4:0] held_p1,
    output logic [1:0] evt_valid,
    output logic [3:0] evt_data_p0,
    output logic [3:0] evt_data_p1,
    input  logic [1:0] evt_ready,
    output logic [1:0] overflow
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    kbd_state_t       state;
    logic [TMR_W-1:0] timer;

    logic             is_prefix;
    logic             dec_vld;
    logic             dec_ext;
    logic             dec_brk;
    key_map_t         key;
    logic [4:0]       act_mask;
    logic [4:0]       cur_held;
    logic             is_held;
    logic             change;
    logic [1:0]       push;
    kbd_evt_t         evt_new;
    logic [1:0]       fifo_full;
    logic [1:0]       pop;

    assign is_prefix = (code_byte == SC_EXT) || (code_byte == SC_BRK);

    // Classify the incoming byte as a completed make/break given the pending prefix state
    always_comb begin
        dec_vld = 1'b0;
        dec_ext = 1'b0;
        dec_brk = 1'b0;
        if (code_valid && !is_prefix) begin
            dec_vld = 1'b1;
            case (state)
                ST_EXT:     dec_ext = 1'b1;
                ST_BRK:     dec_brk = 1'b1;
                ST_EXT_BRK: begin
                    dec_ext = 1'b1;
                    dec_brk = 1'b1;
                end
                default:    dec_ext = 1'b0;
            endcase
        end
    end

    assign key      = map_key(code_byte, dec_ext);
    assign act_mask = 5'b00001 << key.action;
    assign cur_held = key.player ? held_p1 : held_p0;
    assign is_held  = |(cur_held & act_mask);
    // Only level transitions produce events: typematic repeats and stray breaks are ignored
    assign change   = dec_vld & key.hit & (dec_brk ? is_held : ~is_held);
    assign push     = {change & key.player, change & ~key.player};
    assign evt_new  = '{press: ~dec_brk, action: key.action};
    assign pop      = evt_valid & evt_ready;

    // Prefix-tracking FSM with inter-byte timeout, plus the held-action level registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            timer   <= '0;
            held_p0 <= '0;
            held_p1 <= '0;
        end else begin
            if (change) begin
                if (key.player) held_p1 <= dec_brk ? (held_p1 & ~act_mask) : (held_p1 | act_mask);
                else            held_p0 <= dec_brk ? (held_p0 & ~act_mask) : (held_p0 | act_mask);
            end

            if (code_valid) begin
                timer <= '0;
                case (state)
                    ST_IDLE: begin
                        if (code_byte == SC_EXT)      state <= ST_EXT;
                        else if (code_byte == SC_BRK) state <= ST_BRK;
                        else                          state <= ST_IDLE;
                    end
                    ST_EXT: begin
                        if (code_byte == SC_BRK)      state <= ST_EXT_BRK;
                        else if (code_byte == SC_EXT) state <= ST_EXT;
                        else                          state <= ST_IDLE;
                    end
                    // A completing byte or a misplaced prefix both end the sequence
                    ST_BRK:     state <= ST_IDLE;
                    ST_EXT_BRK: state <= ST_IDLE;
                    default:    state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE) begin
                if (timer == TMR_LAST) begin
                    state <= ST_IDLE;
                    timer <= '0;
                end else begin
                    timer <= timer + TMR_W'(1);
                end
            end else begin
                timer <= '0;
            end
        end
    end

    // Flag events that could not be queued; the level state has already been updated
    always_ff @(posedge clk or posedge rst) begin
        if (rst) overflow <= '0;
        else     overflow <= push & fifo_full & ~pop;
    end

    kbd_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo_p0 (
        .clk      (clk),
        .rst      (rst),
        .push     (push[0]),
        .data_in  (evt_new),
        .pop      (evt_ready[0]),
        .valid    (evt_valid[0]),
        .data_out (evt_data_p0),
        .full     (fifo_full[0])
    );

    kbd_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo_p1 (
        .clk      (clk),
        .rst      (rst),
        .push     (push[1]),
        .data_in  (evt_new),
        .pop      (evt_ready[1]),
        .valid    (evt_valid[1]),
        .data_out (evt_data_p1),
        .full     (fifo_full[1])
    );

endmodule

// File: tb/tb_kbd_action_scheduler.sv
// Directed bench for kbd_action_scheduler with a short timeout.
// Latency: expects held/event updates one cycle after each byte.
// Backpressure: drives evt_ready per scenario to exercise full/pop paths.
module tb_kbd_action_scheduler;

    localparam int T_OUT = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] code_byte = 8'h00;
    logic       code_valid = 1'b0;
    logic [4:0] held_p0;
    logic [4:0] held_p1;
    logic [1:0] evt_valid;
    logic [3:0] evt_data_p0;
    logic [3:0] evt_data_p1;
    logic [1:0] evt_ready = 2'b00;
    logic [1:0] overflow;

    int total = 0;
    int bad   = 0;

    kbd_action_scheduler #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (T_OUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .code_byte   (code_byte),
        .code_valid  (code_valid),
        .held_p0     (held_p0),
        .held_p1     (held_p1),
        .evt_valid   (evt_valid),
        .evt_data_p0 (evt_data_p0),
        .evt_data_p1 (evt_data_p1),
        .evt_ready   (evt_ready),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        code_byte  = b;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        code_byte  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pop(input int p);
        evt_ready[p] = 1'b1;
        tick();
        evt_ready = 2'b00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (held_p0 !== 5'b0) begin bad++; $display("FAIL reset_held_p0: got %b expected %b", held_p0, 5'b0); end
        total++; if (held_p1 !== 5'b0) begin bad++; $display("FAIL reset_held_p1: got %b expected %b", held_p1, 5'b0); end
        total++; if (evt_valid !== 2'b0) begin bad++; $display("FAIL reset_evt_valid: got %b expected %b", evt_valid, 2'b0); end
        total++; if ({evt_data_p0, evt_data_p1} !== 8'h00) begin bad++; $display("FAIL reset_evt_data: got %h expected %h", {evt_data_p0, evt_data_p1}, 8'h00); end
        total++; if (overflow !== 2'b0) begin bad++; $display("FAIL reset_overflow: got %b expected %b", overflow, 2'b0); end
    endtask

    task automatic test_p0_make_break();
        send_byte(8'h1D);
        total++; if (held_p0 !== 5'b00001) begin bad++; $display("FAIL p0_make_held: got %b expected %b", held_p0, 5'b00001); end
        total++; if (evt_valid !== 2'b01) begin bad++; $display("FAIL p0_make_valid: got %b expected %b", evt_valid, 2'b01); end
        total++; if (evt_data_p0 !== 4'h8) begin bad++; $display("FAIL p0_make_data: got %h expected %h", evt_data_p0, 4'h8); end
        send_byte(8'hF0);
        total++; if (held_p0 !== 5'b00001) begin bad++; $display("FAIL p0_brk_prefix_held: got %b expected %b", held_p0, 5'b00001); end
        send_byte(8'h1D);
        total++; if (held_p0 !== 5'b00000) begin bad++; $display("FAIL p0_break_held: got %b expected %b", held_p0, 5'b00000); end
        total++; if (evt_data_p0 !== 4'h8) begin bad++; $display("FAIL p0_head_kept: got %h expected %h", evt_data_p0, 4'h8); end
        pop(0);
        total++; if (evt_valid !== 2'b01 || evt_data_p0 !== 4'h0) begin bad++; $display("FAIL p0_second_entry: got v=%b d=%h expected v=01 d=0", evt_valid, evt_data_p0); end
        pop(0);
        total++; if (evt_valid !== 2'b00 || evt_data_p0 !== 4'h0) begin bad++; $display("FAIL p0_drained: got v=%b d=%h expected v=00 d=0", evt_valid, evt_data_p0); end
    endtask

    task automatic test_p1_repeat();
        send_byte(8'hE0); send_byte(8'h75);
        total++; if (held_p1 !== 5'b00001) begin bad++; $display("FAIL p1_make_held: got %b expected %b", held_p1, 5'b00001); end
        total++; if (evt_valid !== 2'b10 || evt_data_p1 !== 4'h8) begin bad++; $display("FAIL p1_make_evt: got v=%b d=%h expected v=10 d=8", evt_valid, evt_data_p1); end
        send_byte(8'hE0); send_byte(8'h75);
        total++; if (held_p1 !== 5'b00001) begin bad++; $display("FAIL p1_repeat_held: got %b expected %b", held_p1, 5'b00001); end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        total++; if (held_p1 !== 5'b00000) begin bad++; $display("FAIL p1_break_held: got %b expected %b", held_p1, 5'b00000); end
        pop(1);
        total++; if (evt_valid !== 2'b10 || evt_data_p1 !== 4'h0) begin bad++; $display("FAIL p1_second_entry: got v=%b d=%h expected v=10 d=0", evt_valid, evt_data_p1); end
        pop(1);
        total++; if (evt_valid !== 2'b00) begin bad++; $display("FAIL p1_only_two_events: got %b expected %b", evt_valid, 2'b00); end
    endtask

    task automatic test_overflow();
        send_byte(8'h1D); send_byte(8'h1B); send_byte(8'h1C); send_byte(8'h23);
        total++; if (overflow !== 2'b00) begin bad++; $display("FAIL ovf_not_yet: got %b expected %b", overflow, 2'b00); end
        send_byte(8'h29);
        total++; if (overflow !== 2'b01) begin bad++; $display("FAIL ovf_pulse: got %b expected %b", overflow, 2'b01); end
        total++; if (held_p0 !== 5'b11111) begin bad++; $display("FAIL ovf_held: got %b expected %b", held_p0, 5'b11111); end
        tick();
        total++; if (overflow !== 2'b00) begin bad++; $display("FAIL ovf_one_cycle: got %b expected %b", overflow, 2'b00); end
        total++; if (evt_data_p0 !== 4'h8) begin bad++; $display("FAIL ovf_head: got %h expected %h", evt_data_p0, 4'h8); end
    endtask

    task automatic test_full_push_pop();
        logic [3:0] exp_q [4];
        exp_q = '{4'h9, 4'hA, 4'hB, 4'h4};
        send_byte(8'hF0);
        code_byte  = 8'h29;
        code_valid = 1'b1;
        evt_ready  = 2'b01;
        tick();
        code_valid = 1'b0;
        code_byte  = 8'h00;
        evt_ready  = 2'b00;
        total++; if (overflow !== 2'b00) begin bad++; $display("FAIL fullpp_no_ovf: got %b expected %b", overflow, 2'b00); end
        total++; if (held_p0 !== 5'b01111) begin bad++; $display("FAIL fullpp_held: got %b expected %b", held_p0, 5'b01111); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (evt_valid[0] !== 1'b1 || evt_data_p0 !== exp_q[i]) begin
                bad++; $display("FAIL fullpp_entry%0d: got v=%b d=%h expected v=1 d=%h", i, evt_valid[0], evt_data_p0, exp_q[i]);
            end
            pop(0);
        end
        total++; if (evt_valid !== 2'b00) begin bad++; $display("FAIL fullpp_count4: got %b expected %b", evt_valid, 2'b00); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_byte(8'h1B); send_byte(8'hE0); send_byte(8'h6B); send_byte(8'h29);
        total++; if (held_p0 !== 5'b10010) begin bad++; $display("FAIL b2b_held_p0: got %b expected %b", held_p0, 5'b10010); end
        total++; if (held_p1 !== 5'b00100) begin bad++; $display("FAIL b2b_held_p1: got %b expected %b", held_p1, 5'b00100); end
        total++; if (evt_data_p0 !== 4'h9 || evt_data_p1 !== 4'hA) begin bad++; $display("FAIL b2b_heads: got p0=%h p1=%h expected p0=9 p1=a", evt_data_p0, evt_data_p1); end
        evt_ready = 2'b11;
        tick();
        evt_ready = 2'b00;
        total++; if (evt_valid !== 2'b01 || evt_data_p0 !== 4'hC) begin bad++; $display("FAIL b2b_dual_pop: got v=%b d=%h expected v=01 d=c", evt_valid, evt_data_p0); end
        pop(0);
        total++; if (evt_valid !== 2'b00) begin bad++; $display("FAIL b2b_drained: got %b expected %b", evt_valid, 2'b00); end
    endtask

    task automatic test_prefix_abort();
        send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h1D);
        total++; if (held_p0 !== 5'b10011) begin bad++; $display("FAIL brk_abort_held: got %b expected %b", held_p0, 5'b10011); end
        total++; if (evt_data_p0 !== 4'h8) begin bad++; $display("FAIL brk_abort_evt: got %h expected %h", evt_data_p0, 4'h8); end
        pop(0);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'hF0); send_byte(8'h5A);
        total++; if (held_p1 !== 5'b10100) begin bad++; $display("FAIL extbrk_abort_held: got %b expected %b", held_p1, 5'b10100); end
        total++; if (evt_data_p1 !== 4'hC) begin bad++; $display("FAIL extbrk_abort_evt: got %h expected %h", evt_data_p1, 4'hC); end
        pop(1);
    endtask

    task automatic test_timeout();
        do_reset();
        send_byte(8'hE0);
        idle(T_OUT);
        send_byte(8'h75);
        total++; if (held_p1 !== 5'b00000) begin bad++; $display("FAIL timeout_held: got %b expected %b", held_p1, 5'b00000); end
        total++; if (evt_valid !== 2'b00) begin bad++; $display("FAIL timeout_no_evt: got %b expected %b", evt_valid, 2'b00); end
        send_byte(8'hE0);
        idle(T_OUT - 2);
        send_byte(8'h75);
        total++; if (held_p1 !== 5'b00001) begin bad++; $display("FAIL before_timeout_held: got %b expected %b", held_p1, 5'b00001); end
        total++; if (evt_valid !== 2'b10) begin bad++; $display("FAIL before_timeout_evt: got %b expected %b", evt_valid, 2'b10); end
    endtask

    task automatic test_reset_mid_seq();
        send_byte(8'hE0); send_byte(8'hF0);
        rst = 1'b1;
        #1;
        total++; if (held_p1 !== 5'b0 || evt_valid !== 2'b0) begin bad++; $display("FAIL async_reset: got held_p1=%b v=%b expected 0", held_p1, evt_valid); end
        tick();
        rst = 1'b0;
        tick();
        send_byte(8'h72);
        total++; if ({held_p0, held_p1} !== 10'b0) begin bad++; $display("FAIL midrst_held: got %b expected 0", {held_p0, held_p1}); end
        total++; if (evt_valid !== 2'b00 || overflow !== 2'b00) begin bad++; $display("FAIL midrst_evt: got v=%b o=%b expected 0", evt_valid, overflow); end
        send_byte(8'hE0); send_byte(8'hF0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        send_byte(8'h1D);
        total++; if (held_p0 !== 5'b00001) begin bad++; $display("FAIL midrst_idle_decode: got %b expected %b", held_p0, 5'b00001); end
    endtask

    initial begin
        test_reset();
        test_p0_make_break();
        test_p1_repeat();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_prefix_abort();
        test_timeout();
        test_reset_mid_seq();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
